trace_fifo_axis_packer: RTL
===========================

# trace_fifo_axis_packer

Drain stage for the monitoring trace FIFO. Pops fixed-width words from the synchronous FIFO's first-word-fall-through read port and packs WORDS_PER_BEAT words into one wide AXI4-Stream beat. Beats are grouped into packets of a programmable length for the downstream DMA, and `tlast` marks the end of each packet. A flush request closes a partial packet so the host can collect trailing trace data.

## Interface
- DATA_WIDTH, 32, width of one FIFO word; must be a multiple of 8
- WORDS_PER_BEAT, 2, FIFO words per output beat; must be ≥1
- CNT_WIDTH, 16, width of `pkt_beats` and the internal beat counter
- clk  in  1  single clock; all logic rising-edge
- rst_n  in  1  reset, synchronous, active-low
- fifo_rd_en  out  1  pop strobe to FIFO; combinational
- fifo_rd_data  in  DATA_WIDTH  FIFO head word, valid whenever `fifo_empty`=0
- fifo_empty  in  1  FIFO empty flag
- pkt_beats  in  CNT_WIDTH  beats per packet; 0 is treated as 1
- flush  in  1  single-cycle request to close the current packet
- m_axis_tdata  out  DATA_WIDTH*WORDS_PER_BEAT  packed beat; word 0 (first popped) in the LSBs
- m_axis_tkeep  out  DATA_WIDTH*WORDS_PER_BEAT/8  byte enables
- m_axis_tvalid  out  1  beat valid
- m_axis_tready  in  1  downstream ready
- m_axis_tlast  out  1  last beat of packet
- pkt_count  out  32  number of completed packets (tlast handshakes); wraps
- busy  out  1  high when `word_idx`≠0, `beat_cnt`≠0, `flush_pend`=1 or state is SEND

## Operation
- **State machine**
  - FILL: collect words into the beat register.
  - SEND: hold the beat until it is accepted.
- **Internal state**
  - `word_idx` (0..WORDS_PER_BEAT-1)
  - `beat_cnt` (CNT_WIDTH)
  - `pkt_len` (latched packet length)
  - `flush_pend`
- **FIFO pop rule:** `fifo_rd_en = (state==FILL) & !fifo_empty`.
- **On each pop:**
  - Store `fifo_rd_data` in slot `word_idx`.
  - Set that slot's tkeep bytes.
  - Increment `word_idx`.
- **Length latch:** if the pop is the first of a packet (`beat_cnt==0 && word_idx==0`), latch `pkt_len = max(pkt_beats,1)`.
- **Full beat:** a pop into the last slot resets `word_idx` to 0 and moves to SEND next cycle with `tvalid=1`.
  - tkeep is all ones.
  - `tlast = (beat_cnt == pkt_len-1)`.
- **Handshake** (`tvalid & tready` in SEND):
  - Increment `beat_cnt`.
  - If tlast: clear `beat_cnt` and increment `pkt_count`.
  - Clear the beat register and tkeep; return to FILL.
- **Flush latch:** `flush` sets `flush_pend` in any state. It is not lost if it arrives during SEND.
- **Flush service:** acted on only in FILL with `fifo_empty=1` (the FIFO drains first).
  - `word_idx>0`: send the partial beat; tkeep covers only the filled words, unfilled bits are 0, `tlast=1`.
  - `word_idx==0` and `beat_cnt>0`: send a null beat; tdata=0, tkeep=0, `tlast=1`.
  - Both zero: nothing is sent.
  - In every case: clear `flush_pend`. Both sending cases go to SEND. On handshake, `beat_cnt` is cleared and `pkt_count` increments.
- **Flush re-arm:** a `flush` in the same cycle the pending flush is serviced sets `flush_pend` again (set wins).
- **No reads in SEND:** `fifo_rd_en` is 0 while a beat waits on `tready`, so the FIFO absorbs backpressure.

## Timing
- **Reset values** (`rst_n=0` at a clock edge):
  - State = FILL.
  - `fifo_rd_en=0` (empty permitting).
  - tdata=0, tkeep=0, tvalid=0, tlast=0.
  - `pkt_count=0`, `busy=0`.
  - `word_idx=0`, `beat_cnt=0`, `flush_pend=0`.
- **Reset mid-operation** discards the partial beat and any pending flush. An un-accepted beat is dropped.
- **Latency:** the pop of a beat's last word is at cycle N; tvalid=1 from cycle N+1.
  - Best-case throughput: WORDS_PER_BEAT+1 cycles per beat.
- **AXI rule:** tdata, tkeep and tlast are stable while `tvalid=1 && tready=0`. tvalid is never withdrawn before handshake.
- **Packet length:** `pkt_beats` changes mid-packet have no effect until the next packet's first pop.
- **Width rule:** `beat_cnt` compares against `pkt_len-1` with no overflow, since `pkt_len≥1`.
- **Counter wrap:** `pkt_count` wraps 0xFFFFFFFF→0.

## Test plan
- Reset, then push 4 words 0x11,0x22,0x33,0x44 with `pkt_beats=2`, `tready=1` → beats 0x00000022_00000011 (tlast=0) then 0x00000044_00000033 (tlast=1), tkeep=0xFF, `pkt_count=1`.
- Same stimulus with `tready=0` for 5 cycles on beat 1 → tdata/tlast held stable, `fifo_rd_en=0` throughout, beat order unchanged.
- Push 3 words with `pkt_beats=4`, then pulse `flush` → after the FIFO empties, beat 2 = {0,word2}, tkeep=0x0F, tlast=1; `beat_cnt` returns to 0.
- Push 2 words (one full beat, `pkt_beats=4`), then `flush` → null beat, tkeep=0x00, tdata=0, tlast=1, `pkt_count=1`.
- `flush` with the block idle → no beat is produced and `busy` stays 0. `pkt_beats=0` with 2 words → a single beat with tlast=1.
- Assert `rst_n=0` with 1 word buffered and `flush_pend=1` → next packet starts fresh: word0 in the LSBs, `pkt_count=0`, no spurious tlast.

Source files
------------

// File: rtl/trace_fifo_axis_packer.sv
// rtl/trace_fifo_axis_packer.sv - packs FWFT trace FIFO words into AXI-Stream beats and packets
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   fifo_rd_en          pop strobe to the FIFO (combinational)
//   fifo_rd_data        FIFO head word, valid while fifo_empty=0
//   fifo_empty          FIFO empty flag
//   pkt_beats           beats per packet (0 treated as 1), sampled on a packet's first pop
//   flush               single-cycle request to close the current packet
//   m_axis_t*           output stream (tdata/tkeep/tvalid/tready/tlast)
//   pkt_count           completed packets (tlast handshakes), wraps
//   busy                a beat, packet or flush is in progress
module trace_fifo_axis_packer #(
  parameter int DATA_WIDTH     = 32,
  parameter int WORDS_PER_BEAT = 2,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  output logic                                 fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]                fifo_rd_data,
  input  logic                                 fifo_empty,
  input  logic [CNT_WIDTH-1:0]                 pkt_beats,
  input  logic                                 flush,
  output logic [DATA_WIDTH*WORDS_PER_BEAT-1:0] m_axis_tdata,
  output logic [DATA_WIDTH*WORDS_PER_BEAT/8-1:0] m_axis_tkeep,
  output logic                                 m_axis_tvalid,
  input  logic                                 m_axis_tready,
  output logic                                 m_axis_tlast,
  output logic [31:0]                          pkt_count,
  output logic                                 busy
);

  localparam int WORD_KEEP = DATA_WIDTH / 8;
  localparam int IDX_W     = (WORDS_PER_BEAT > 1) ? $clog2(WORDS_PER_BEAT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_BEAT - 1);

  typedef enum logic {FILL = 1'b0, SEND = 1'b1} state_t;

  state_t               state;
  logic [IDX_W-1:0]     word_idx;
  logic [CNT_WIDTH-1:0] beat_cnt;
  logic [CNT_WIDTH-1:0] pkt_len;
  logic                 flush_pend;

  logic                 pop;
  logic                 first_pop;
  logic                 flush_svc;
  logic [CNT_WIDTH-1:0] len_in;
  logic [CNT_WIDTH-1:0] cur_len;
  int                   slot_lsb;

  always_comb begin
    pop       = (state == FILL) && !fifo_empty;
    first_pop = (beat_cnt == '0) && (word_idx == '0);
    len_in    = (pkt_beats == '0) ? CNT_WIDTH'(1) : pkt_beats;
    // On a packet's first pop pkt_len is only being latched, so use the
    // incoming length directly (matters when a single word fills a beat).
    cur_len   = first_pop ? len_in : pkt_len;
    // Flush waits for the FIFO to drain so trailing words are not stranded.
    flush_svc = (state == FILL) && fifo_empty && flush_pend;
    slot_lsb  = int'(word_idx) * DATA_WIDTH;
  end

  assign fifo_rd_en = pop;
  assign busy       = (word_idx != '0) || (beat_cnt != '0) || flush_pend || (state == SEND);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= FILL;
      word_idx      <= '0;
      beat_cnt      <= '0;
      pkt_len       <= CNT_WIDTH'(1);
      flush_pend    <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      pkt_count     <= '0;
    end else begin
      // A new request in the servicing cycle re-arms the flag.
      flush_pend <= flush || (flush_pend && !flush_svc);

      case (state)
        FILL: begin
          if (pop) begin
            m_axis_tdata[slot_lsb +: DATA_WIDTH]                     <= fifo_rd_data;
            m_axis_tkeep[int'(word_idx) * WORD_KEEP +: WORD_KEEP]    <= '1;
            if (first_pop) begin
              pkt_len <= len_in;
            end
            if (word_idx == LAST_IDX) begin
              word_idx      <= '0;
              m_axis_tvalid <= 1'b1;
              m_axis_tlast  <= (beat_cnt == cur_len - CNT_WIDTH'(1));
              state         <= SEND;
            end else begin
              word_idx <= word_idx + IDX_W'(1);
            end
          end else if (flush_svc) begin
            if (word_idx != '0) begin
              // Partial beat: unfilled slots are already zero from the last clear.
              word_idx      <= '0;
              m_axis_tvalid <= 1'b1;
              m_axis_tlast  <= 1'b1;
              state         <= SEND;
            end else if (beat_cnt != '0) begin
              // Null beat closes a packet whose data ended on a beat boundary.
              m_axis_tdata  <= '0;
              m_axis_tkeep  <= '0;
              m_axis_tvalid <= 1'b1;
              m_axis_tlast  <= 1'b1;
              state         <= SEND;
            end
          end
        end

        SEND: begin
          if (m_axis_tready) begin
            if (m_axis_tlast) begin
              beat_cnt  <= '0;
              pkt_count <= pkt_count + 32'd1;
            end else begin
              beat_cnt <= beat_cnt + CNT_WIDTH'(1);
            end
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            state         <= FILL;
          end
        end
      endcase
    end
  end

endmodule
